blk_tdp_ram: RTL and testbench

Single-clock true dual-port block RAM with per-byte write enables, selectable read latency, per-port write modes and a deterministic same-address collision policy. After reset, a clear sequencer fills the array with a known value before any port access is accepted. It is the generalised successor to the behavioral dual-port RAM model. It serves as the shared buffer primitive for GBA-side FIFOs, line buffers and register files.

---
 rtl/blk_tdp_ram_if.sv | 39 +++
 rtl/blk_tdp_ram.sv | 217 +++++++++++++++++++++
 tb/tb_blk_tdp_ram.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/blk_tdp_ram_if.sv
// Port bundle for blk_tdp_ram: two independent access ports plus clear/status.
// master drives accesses, slave is the RAM.
interface blk_tdp_ram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  init_req;
  logic                  ready;

  logic                  a_en;
  logic [NB-1:0]         a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic [DATA_WIDTH-1:0] a_dout;
  logic                  a_valid;

  logic                  b_en;
  logic [NB-1:0]         b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_din;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_valid;

  logic                  collision;
  logic [15:0]           coll_cnt;

  modport master (
    output init_req, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din,
    input  ready, a_dout, a_valid, b_dout, b_valid, collision, coll_cnt
  );

  modport slave (
    input  init_req, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din,
    output ready, a_dout, a_valid, b_dout, b_valid, collision, coll_cnt
  );
endinterface

// File: rtl/blk_tdp_ram.sv
// True dual-port byte-enable RAM with clear sequencer and same-address collision policy.
// Optional saturating collision counter: define BLK_TDP_RAM_COLL_CNT_EN.

// One byte lane of the write merge; port A wins lanes both ports write.
module blk_tdp_ram_lane #(
  parameter int BW = 8
) (
  input  logic          same,
  input  logic          a_we,
  input  logic          b_we,
  input  logic [BW-1:0] a_din,
  input  logic [BW-1:0] b_din,
  input  logic [BW-1:0] old_a,
  input  logic [BW-1:0] old_b,
  output logic [BW-1:0] fin_a,
  output logic [BW-1:0] fin_b
);
  always_comb begin
    fin_a = old_a;
    if (a_we)              fin_a = a_din;
    else if (same && b_we) fin_a = b_din;
    fin_b = old_b;
    if (same && a_we)      fin_b = a_din;
    else if (b_we)         fin_b = b_din;
  end
endmodule

// Per-port output pipeline; dout only moves when a valid word advances.
module blk_tdp_ram_port #(
  parameter int DW   = 32,
  parameter int RL   = 1,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,
  input  logic          wr,
  input  logic [DW-1:0] old,
  input  logic [DW-1:0] fin,
  output logic [DW-1:0] dout,
  output logic          valid
);
  logic              vld_in;
  logic [DW-1:0]     dat_in;
  logic [RL:0]       vld_pipe;
  logic [RL:1]       vld_q;
  logic [RL:0][DW-1:0] dat_pipe;
  logic [RL:1][DW-1:0] dat_q;

  assign vld_in   = acc && (!wr || (MODE != 2));
  assign dat_in   = (wr && (MODE == 0)) ? fin : old;
  assign vld_pipe = {vld_q, vld_in};
  assign dat_pipe = {dat_q, dat_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[RL-1:0];
      for (int k = 1; k <= RL; k++)
        if (vld_pipe[k-1]) dat_q[k] <= dat_pipe[k-1];
    end
  end

  assign dout  = dat_q[RL];
  assign valid = vld_q[RL];
endmodule

module blk_tdp_ram #(
  parameter int                  ADDR_WIDTH   = 10,
  parameter int                  DATA_WIDTH   = 32,
  parameter int                  BYTE_WIDTH   = 8,
  parameter int                  READ_LATENCY = 1,
  parameter int                  WRITE_MODE_A = 0,
  parameter int                  WRITE_MODE_B = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic           clk,
  input logic           rst_n,
  blk_tdp_ram_if.slave  bus
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int D  = 1 << ADDR_WIDTH;
  localparam int RL = READ_LATENCY;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  ready;

  assign ready     = (state == ST_READY);
  assign bus.ready = ready;

  // Counter wraps to 0 naturally after D-1, so only the state needs to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= ST_READY;
        end
        default: begin
          if (bus.init_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  logic acc_a, acc_b, wr_a, wr_b, same, coll_now;
  logic [NB-1:0] a_we_g, b_we_g;
  logic [DATA_WIDTH-1:0] old_a, old_b, fin_a, fin_b;
  logic [NB-1:0][BYTE_WIDTH-1:0] a_din_l, b_din_l, old_a_l, old_b_l, fin_a_l, fin_b_l;

  assign acc_a    = bus.a_en && ready;
  assign acc_b    = bus.b_en && ready;
  assign a_we_g   = acc_a ? bus.a_we : '0;
  assign b_we_g   = acc_b ? bus.b_we : '0;
  assign wr_a     = |a_we_g;
  assign wr_b     = |b_we_g;
  assign same     = acc_a && acc_b && (bus.a_addr == bus.b_addr);
  assign coll_now = same && (wr_a || wr_b);

  logic [DATA_WIDTH-1:0] mem [D];

  assign old_a   = mem[bus.a_addr];
  assign old_b   = mem[bus.b_addr];
  assign old_a_l = old_a;
  assign old_b_l = old_b;
  assign a_din_l = bus.a_din;
  assign b_din_l = bus.b_din;
  assign fin_a   = fin_a_l;
  assign fin_b   = fin_b_l;

  for (genvar l = 0; l < NB; l++) begin : g_lane
    blk_tdp_ram_lane #(.BW(BYTE_WIDTH)) u_lane (
      .same  (same),
      .a_we  (a_we_g[l]),
      .b_we  (b_we_g[l]),
      .a_din (a_din_l[l]),
      .b_din (b_din_l[l]),
      .old_a (old_a_l[l]),
      .old_b (old_b_l[l]),
      .fin_a (fin_a_l[l]),
      .fin_b (fin_b_l[l])
    );
  end

  // Both ports write the fully merged word, so a same-address double write is coherent.
  always_ff @(posedge clk) begin
    if (rst_n && !ready) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else begin
      if (wr_b) mem[bus.b_addr] <= fin_b;
      if (wr_a) mem[bus.a_addr] <= fin_a;
    end
  end

  blk_tdp_ram_port #(.DW(DATA_WIDTH), .RL(RL), .MODE(WRITE_MODE_A)) u_port_a (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (acc_a),
    .wr    (wr_a),
    .old   (old_a),
    .fin   (fin_a),
    .dout  (bus.a_dout),
    .valid (bus.a_valid)
  );

  blk_tdp_ram_port #(.DW(DATA_WIDTH), .RL(RL), .MODE(WRITE_MODE_B)) u_port_b (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (acc_b),
    .wr    (wr_b),
    .old   (old_b),
    .fin   (fin_b),
    .dout  (bus.b_dout),
    .valid (bus.b_valid)
  );

  logic [RL:0] coll_pipe;
  logic [RL:1] coll_q;

  assign coll_pipe = {coll_q, coll_now};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= '0;
    else        coll_q <= coll_pipe[RL-1:0];
  end

  assign bus.collision = coll_q[RL];

`ifdef BLK_TDP_RAM_COLL_CNT_EN
  logic [15:0] coll_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      coll_cnt_q <= '0;
    else if (ready && bus.init_req)
      coll_cnt_q <= '0;
    else if (bus.collision && (coll_cnt_q != 16'hFFFF))
      coll_cnt_q <= coll_cnt_q + 16'd1;
  end

  assign bus.coll_cnt = coll_cnt_q;
`else
  assign bus.coll_cnt = '0;
`endif
endmodule

// File: tb/tb_blk_tdp_ram.sv
// Scoreboard bench: four RAM builds (mode A 0/1/2 at latency 1, mode 0 at latency 2) driven in lockstep.
module tb_blk_tdp_ram;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int ND = 4;
  localparam logic [31:0] INIT = 32'hDEADBEEF;
`ifdef BLK_TDP_RAM_COLL_CNT_EN
  localparam logic [31:0] CNT1 = 32'd1;
`else
  localparam logic [31:0] CNT1 = 32'd0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        init_req, a_en, b_en;
  logic [3:0]  a_we, b_we, a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [ND-1:0]       ready_w, a_valid_w, b_valid_w, coll_w;
  logic [ND-1:0][31:0] a_dout_w, b_dout_w;
  logic [ND-1:0][15:0] cnt_w;

  exp_t qa[ND][$];
  exp_t qb[ND][$];
  int   checks = 0;
  int   errors = 0;
  int   ncoll[ND] = '{default: 0};
  int   ecoll = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int MA = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    localparam int RL = (g == 3) ? 2 : 1;

    blk_tdp_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

    assign bus.init_req = init_req;
    assign bus.a_en     = a_en;
    assign bus.a_we     = a_we;
    assign bus.a_addr   = a_addr;
    assign bus.a_din    = a_din;
    assign bus.b_en     = b_en;
    assign bus.b_we     = b_we;
    assign bus.b_addr   = b_addr;
    assign bus.b_din    = b_din;
    assign ready_w[g]   = bus.ready;
    assign a_valid_w[g] = bus.a_valid;
    assign b_valid_w[g] = bus.b_valid;
    assign a_dout_w[g]  = bus.a_dout;
    assign b_dout_w[g]  = bus.b_dout;
    assign coll_w[g]    = bus.collision;
    assign cnt_w[g]     = bus.coll_cnt;

    blk_tdp_ram #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(RL),
      .WRITE_MODE_A(MA), .WRITE_MODE_B(0), .INIT_VALUE(INIT)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (bus.a_valid) begin
        checks++;
        if (qa[g].size() == 0) begin
          errors++;
          $display("FAIL a_unexpected dut%0d got %h", g, bus.a_dout);
        end else begin
          e = qa[g].pop_front();
          if (bus.a_dout !== e.d) begin
            errors++;
            $display("FAIL a_dout dut%0d got %h exp %h", g, bus.a_dout, e.d);
          end
        end
      end
      if (bus.b_valid) begin
        checks++;
        if (qb[g].size() == 0) begin
          errors++;
          $display("FAIL b_unexpected dut%0d got %h", g, bus.b_dout);
        end else begin
          e = qb[g].pop_front();
          if (bus.b_dout !== e.d || bus.collision !== e.c) begin
            errors++;
            $display("FAIL b_dout dut%0d got %h/coll %b exp %h/coll %b",
                     g, bus.b_dout, bus.collision, e.d, e.c);
          end
        end
      end
      if (bus.collision) begin
        ncoll[g]++;
        checks++;
        if (!bus.b_valid) begin
          errors++;
          $display("FAIL coll_align dut%0d got b_valid 0 exp 1", g);
        end
      end
    end
  end

  function automatic int mode_a(int g);
    return (g == 1) ? 1 : ((g == 2) ? 2 : 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  // One access cycle on both ports; expectations pushed per build before the edge.
  task automatic acc(input int ae, input int awe, input int aad, input logic [31:0] adi,
                     input logic [31:0] anew, input logic [31:0] aold,
                     input int be, input int bwe, input int bad, input logic [31:0] bdi,
                     input logic [31:0] bexp, input int coll);
    a_en = (ae != 0); a_we = 4'(awe); a_addr = 4'(aad); a_din = adi;
    b_en = (be != 0); b_we = 4'(bwe); b_addr = 4'(bad); b_din = bdi;
    for (int g = 0; g < ND; g++) begin
      if (ae != 0) begin
        if (awe == 0)             qa[g].push_back(exp_t'{d: anew, c: 1'b0});
        else if (mode_a(g) == 0)  qa[g].push_back(exp_t'{d: anew, c: 1'b0});
        else if (mode_a(g) == 1)  qa[g].push_back(exp_t'{d: aold, c: 1'b0});
      end
      if (be != 0) qb[g].push_back(exp_t'{d: bexp, c: (coll != 0)});
    end
    if (coll != 0) ecoll++;
    step();
    a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
  endtask

  logic [3:0]  bad_a[4] = '{4'd3, 4'd5, 4'd7, 4'd0};
  logic [31:0] bex_a[4] = '{32'hDE22BE44, 32'hDEBBAAAA, 32'h12345678, 32'hDEADBEEF};
  logic [31:0] bex_b[4] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDE22BE44};
  logic [5:0]  vp0, vp3;
  logic        seen;

  initial begin
    init_req = 0; a_en = 0; b_en = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_din = 0; b_din = 0;
    vp0 = '0; vp3 = '0; seen = 0;
    step(); step();
    chk("rst_ready", 32'(ready_w), 32'd0);
    chk("rst_valid", 32'({a_valid_w, b_valid_w, coll_w}), 32'd0);
    chk("rst_dout", a_dout_w[0] | a_dout_w[3] | b_dout_w[0] | b_dout_w[3], 32'd0);
    chk("rst_cnt", 32'(cnt_w), 32'd0);

    // Release reset with enables asserted: clear must ignore them.
    rst_n = 1; a_en = 1; b_en = 1; a_addr = 4'd0; b_addr = 4'd1;
    for (int i = 1; i <= 16; i++) begin
      step();
      seen |= (|{a_valid_w, b_valid_w});
      if (i == 15) chk("ready_edge15", 32'(ready_w), 32'd0);
    end
    chk("ready_edge16", 32'(ready_w), 32'hF);
    a_en = 0; b_en = 0;
    step();
    seen |= (|{a_valid_w, b_valid_w});
    chk("clear_no_valid", 32'(seen), 32'd0);

    for (int i = 0; i < 16; i++)
      acc(1, 0, i, 0, INIT, INIT, 1, 0, 15 - i, 0, INIT, 0);
    step(); step();

    acc(1, 4'b0101, 3, 32'h11223344, 32'hDE22BE44, INIT, 0, 0, 0, 0, 0, 0);
    acc(1, 0, 3, 0, 32'hDE22BE44, 32'hDE22BE44, 1, 0, 3, 0, 32'hDE22BE44, 0);
    acc(1, 4'b0011, 5, 32'hAAAAAAAA, 32'hDEBBAAAA, INIT,
        1, 4'b0110, 5, 32'hBBBBBBBB, 32'hDEBBAAAA, 1);
    acc(1, 0, 5, 0, 32'hDEBBAAAA, 32'hDEBBAAAA, 1, 0, 5, 0, 32'hDEBBAAAA, 0);
    chk("coll_cnt_1", 32'(cnt_w[0]), CNT1);
    acc(1, 4'hF, 7, 32'h12345678, 32'h12345678, INIT, 1, 0, 7, 0, INIT, 1);
    chk("nochg_dout", a_dout_w[2], 32'hDEBBAAAA);
    chk("nochg_valid", 32'(a_valid_w[2]), 32'd0);
    acc(1, 0, 7, 0, 32'h12345678, 32'h12345678, 1, 0, 7, 0, 32'h12345678, 0);
    step(); step();

    // Back-to-back burst: latency-2 build sees valid two edges in, unbroken for 4.
    for (int i = 0; i < 4; i++) begin
      acc(1, 0, int'(bad_a[i]), 0, bex_a[i], bex_a[i], 1, 0, i, 0, bex_b[i], 0);
      vp0[i] = a_valid_w[0];
      vp3[i] = a_valid_w[3];
    end
    for (int i = 4; i < 6; i++) begin
      step();
      vp0[i] = a_valid_w[0];
      vp3[i] = a_valid_w[3];
    end
    chk("burst_rl1", 32'(vp0), 32'b001111);
    chk("burst_rl2", 32'(vp3), 32'b011110);

    // Re-clear with a read in flight; init_req held through the clear is ignored.
    init_req = 1;
    acc(1, 0, 7, 0, 32'h12345678, 32'h12345678, 0, 0, 0, 0, 0, 0);
    chk("init_ready0", 32'(ready_w), 32'd0);
    seen = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      seen |= (|ready_w);
    end
    init_req = 0;
    chk("init_ready_low", 32'(seen), 32'd0);
    step();
    chk("init_ready_hi", 32'(ready_w), 32'hF);
    chk("init_cnt_clr", 32'(cnt_w[0]), 32'd0);
    chk("q_drained", 32'(qa[0].size() + qa[3].size() + qb[0].size() + qb[3].size()), 32'd0);

    for (int i = 0; i < 16; i++)
      acc(1, 0, i, 0, INIT, INIT, 1, 0, i, 0, INIT, 0);
    step(); step();

    // Reset in the middle of a re-clear.
    init_req = 1;
    step();
    init_req = 0;
    repeat (5) step();
    #3;
    rst_n = 0;
    #1;
    chk("midrst_ready", 32'(ready_w), 32'd0);
    chk("midrst_valid", 32'({a_valid_w, b_valid_w, coll_w}), 32'd0);
    chk("midrst_dout", a_dout_w[0] | a_dout_w[3] | b_dout_w[0] | b_dout_w[3], 32'd0);
    rst_n = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) chk("midrst_ready15", 32'(ready_w), 32'd0);
    end
    chk("midrst_ready16", 32'(ready_w), 32'hF);

    for (int g = 0; g < ND; g++) begin
      chk($sformatf("coll_pulses_dut%0d", g), 32'(ncoll[g]), 32'(ecoll));
      chk($sformatf("queues_empty_dut%0d", g), 32'(qa[g].size() + qb[g].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
